// File: rtl/bullet_pkg.sv
// Shared types for the bullet pool: scheduler states, per-slot record, direction encoding.
package bullet_pkg;

  localparam int SLOT_CORDW = 16;

  typedef enum logic [1:0] {IDLE, ALLOC, MOVE} state_t;

  typedef struct packed {
    logic                  active;
    logic                  dir;
    logic [SLOT_CORDW-1:0] x;
    logic [SLOT_CORDW-1:0] y;
  } slot_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/free_slot_finder.sv
// Combinational lowest-index free slot finder; slots set in exclude are skipped.
module free_slot_finder #(
  parameter int N_SLOTS = 4
) (
  input  logic [N_SLOTS-1:0]         free,
  input  logic [N_SLOTS-1:0]         exclude,
  output logic                       vld,
  output logic [$clog2(N_SLOTS)-1:0] idx
);

  logic [N_SLOTS-1:0] cand;

  always_comb begin
    cand = free & ~exclude;
    vld  = 1'b0;
    idx  = '0;
    // Scan downward so the lowest candidate is the last one written.
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        vld = 1'b1;
        idx = ($clog2(N_SLOTS))'(i);
      end
    end
  end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Bullet slot scheduler: per frame, one ALLOC cycle (player then alien) followed by
// one MOVE cycle per slot; busy for N_SLOTS+1 cycles after frame.
module bullet_pool_ctrl
  import bullet_pkg::*;
#(
  parameter int N_SLOTS    = 4,
  parameter int CORDW      = SLOT_CORDW,
  parameter int SPEED      = 8,
  parameter int SCREEN_H   = 480,
  parameter int COOLDOWN   = 8,
  parameter int PLAYER_MAX = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame,
  input  logic                     player_fire,
  input  logic [CORDW-1:0]         player_x,
  input  logic [CORDW-1:0]         player_y,
  input  logic                     alien_fire,
  input  logic [CORDW-1:0]         alien_x,
  input  logic [CORDW-1:0]         alien_y,
  input  logic [N_SLOTS-1:0]       hit,
  output logic [N_SLOTS-1:0]       slot_active,
  output logic [N_SLOTS-1:0]       slot_dir,
  output logic [N_SLOTS*CORDW-1:0] slot_x,
  output logic [N_SLOTS*CORDW-1:0] slot_y,
  output logic                     player_grant,
  output logic                     alien_grant,
  output logic                     busy,
  output logic                     frame_overrun
);

  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam int UW = $clog2(N_SLOTS + 1);

  state_t             state;
  slot_t              slots [N_SLOTS];
  logic [N_SLOTS-1:0] fresh;
  logic               player_pend, alien_pend;
  logic [CW-1:0]      cooldown;
  logic [IW-1:0]      idx;

  logic [UW-1:0]      up_count;
  logic               p_vld, a_vld, p_take, a_take;
  logic [IW-1:0]      p_idx, a_idx;
  logic [N_SLOTS-1:0] p_mask;
  logic [CORDW-1:0]   cur_y, mv_y;
  logic [CORDW:0]     down_sum;
  logic               mv_retire;

  always_comb begin
    up_count = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_active[i]             = slots[i].active;
      slot_dir[i]                = slots[i].dir;
      slot_x[i*CORDW +: CORDW]   = CORDW'(slots[i].x);
      slot_y[i*CORDW +: CORDW]   = CORDW'(slots[i].y);
      if (slots[i].active && slots[i].dir == DIR_UP) up_count = up_count + UW'(1);
    end
  end

  assign busy = (state != IDLE);

  free_slot_finder #(.N_SLOTS(N_SLOTS)) u_player_find (
    .free    (~slot_active),
    .exclude ('0),
    .vld     (p_vld),
    .idx     (p_idx)
  );

  // Cooldown here is already the post-decrement value from the IDLE->ALLOC edge.
  assign p_take = (state == ALLOC) && player_pend && (cooldown == '0) &&
                  (up_count < UW'(PLAYER_MAX)) && p_vld;
  assign p_mask = p_take ? (N_SLOTS'(1) << p_idx) : '0;

  free_slot_finder #(.N_SLOTS(N_SLOTS)) u_alien_find (
    .free    (~slot_active),
    .exclude (p_mask),
    .vld     (a_vld),
    .idx     (a_idx)
  );

  assign a_take = (state == ALLOC) && alien_pend && a_vld;

  always_comb begin
    cur_y    = CORDW'(slots[idx].y);
    down_sum = {1'b0, cur_y} + (CORDW+1)'(SPEED);
    if (slots[idx].dir == DIR_UP) begin
      mv_retire = (cur_y < CORDW'(SPEED));
      mv_y      = cur_y - CORDW'(SPEED);
    end else begin
      mv_retire = (down_sum >= (CORDW+1)'(SCREEN_H));
      mv_y      = down_sum[CORDW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fresh         <= '0;
      player_pend   <= 1'b0;
      alien_pend    <= 1'b0;
      cooldown      <= '0;
      idx           <= '0;
      player_grant  <= 1'b0;
      alien_grant   <= 1'b0;
      frame_overrun <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= '0;
    end else begin
      player_grant  <= 1'b0;
      alien_grant   <= 1'b0;
      frame_overrun <= frame && (state != IDLE);
      player_pend   <= player_pend | player_fire;
      alien_pend    <= alien_pend | alien_fire;
      case (state)
        IDLE: begin
          if (frame) begin
            state <= ALLOC;
            if (cooldown != '0) cooldown <= cooldown - CW'(1);
          end
        end
        ALLOC: begin
          player_pend <= 1'b0;
          alien_pend  <= 1'b0;
          fresh       <= '0;
          if (p_take) begin
            slots[p_idx] <= '{active: 1'b1, dir: DIR_UP,
                              x: SLOT_CORDW'(player_x), y: SLOT_CORDW'(player_y)};
            fresh[p_idx] <= 1'b1;
            cooldown     <= CW'(COOLDOWN);
            player_grant <= 1'b1;
          end
          if (a_take) begin
            slots[a_idx] <= '{active: 1'b1, dir: DIR_DOWN,
                              x: SLOT_CORDW'(alien_x), y: SLOT_CORDW'(alien_y)};
            fresh[a_idx] <= 1'b1;
            alien_grant  <= 1'b1;
          end
          idx   <= '0;
          state <= MOVE;
        end
        MOVE: begin
          if (slots[idx].active && !fresh[idx] && !hit[idx]) begin
            if (mv_retire) slots[idx].active <= 1'b0;
            else           slots[idx].y      <= SLOT_CORDW'(mv_y);
          end
          if (idx == IW'(N_SLOTS - 1)) state <= IDLE;
          else                         idx   <= idx + IW'(1);
        end
        default: state <= IDLE;
      endcase
      // A slot allocated this cycle was inactive, so a hit on it cannot kill it.
      for (int i = 0; i < N_SLOTS; i++) begin
        if (hit[i] && slots[i].active) slots[i].active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl with default parameters (4 slots, 16-bit coords).
module tb_bullet_pool_ctrl;

  logic        clk = 1'b0;
  logic        rst, frame, player_fire, alien_fire;
  logic [15:0] player_x, player_y, alien_x, alien_y;
  logic [3:0]  hit;
  logic [3:0]  slot_active, slot_dir;
  logic [63:0] slot_x, slot_y;
  logic        player_grant, alien_grant, busy, frame_overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic pg, ag;
  int gsum;

  always #5 clk = ~clk;

  bullet_pool_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame         (frame),
    .player_fire   (player_fire),
    .player_x      (player_x),
    .player_y      (player_y),
    .alien_fire    (alien_fire),
    .alien_x       (alien_x),
    .alien_y       (alien_y),
    .hit           (hit),
    .slot_active   (slot_active),
    .slot_dir      (slot_dir),
    .slot_x        (slot_x),
    .slot_y        (slot_y),
    .player_grant  (player_grant),
    .alien_grant   (alien_grant),
    .busy          (busy),
    .frame_overrun (frame_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sy(input int i);
    return slot_y[i*16 +: 16];
  endfunction

  function automatic logic [15:0] sx(input int i);
    return slot_x[i*16 +: 16];
  endfunction

  // Frame pulse, ALLOC, then four MOVE cycles; grants are sampled right after ALLOC.
  task automatic run_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    pg = player_grant;
    ag = alien_grant;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; frame = 1'b0; player_fire = 1'b0; alien_fire = 1'b0;
    player_x = '0; player_y = '0; alien_x = '0; alien_y = '0; hit = '0;
    repeat (2) tick();
    chk("rst_active", slot_active, 0);
    chk("rst_y", slot_y[31:0], 0);
    chk("rst_busy", busy, 0);
    chk("rst_grants", {player_grant, alien_grant, frame_overrun}, 0);
    rst = 1'b0;

    // Player spawn at (100,400)
    player_fire = 1'b1; player_x = 16'd100; player_y = 16'd400;
    tick();
    player_fire = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("busy_alloc", busy, 1);
    tick();
    chk("p_grant", player_grant, 1);
    chk("a_grant_none", alien_grant, 0);
    chk("spawn_active", slot_active, 4'b0001);
    chk("spawn_dir", slot_dir[0], 1);
    chk("spawn_x", sx(0), 100);
    chk("spawn_y", sy(0), 400);
    tick();
    chk("grant_one_cycle", player_grant, 0);
    repeat (3) tick();
    chk("busy_done", busy, 0);
    chk("fresh_not_moved", sy(0), 400);

    // Next frame moves it up; fire now held
    player_fire = 1'b1;
    run_frame();
    chk("move_up", sy(0), 392);
    chk("cd_deny_f2", pg, 0);

    // Kill with hit while idle; position kept
    hit = 4'b0001;
    tick();
    hit = '0;
    chk("hit_idle", slot_active, 0);
    chk("hit_keeps_y", sy(0), 392);

    gsum = 0;
    for (int f = 3; f <= 8; f++) begin
      run_frame();
      gsum += pg;
    end
    chk("cooldown_block", gsum, 0);
    run_frame();
    chk("cooldown_f9", pg, 1);
    chk("regrant_slot0", slot_active, 4'b0001);
    chk("regrant_y", sy(0), 400);

    for (int f = 10; f <= 17; f++) run_frame();
    chk("pmax_deny", pg, 0);
    chk("pmax_y", sy(0), 336);
    player_fire = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Downward bullet from 470: 478, then retires at 486
    alien_fire = 1'b1; alien_x = 16'd50; alien_y = 16'd470;
    tick();
    alien_fire = 1'b0;
    run_frame();
    chk("a_grant", ag, 1);
    chk("a_dir", slot_dir[0], 0);
    chk("a_y", sy(0), 470);
    run_frame();
    chk("a_move", sy(0), 478);
    chk("a_still_active", slot_active[0], 1);
    run_frame();
    chk("a_retire", slot_active[0], 0);
    chk("a_retire_y", sy(0), 478);

    // Upward bullet from y=5 retires on the first move
    player_fire = 1'b1; player_y = 16'd5;
    tick();
    player_fire = 1'b0;
    run_frame();
    chk("up5_grant", pg, 1);
    run_frame();
    chk("up5_retire", slot_active[0], 0);
    chk("up5_y", sy(0), 5);

    // Fill all four slots with aliens from y=0
    alien_y = 16'd0;
    for (int k = 0; k < 4; k++) begin
      alien_fire = 1'b1;
      tick();
      alien_fire = 1'b0;
      run_frame();
    end
    chk("pool_full", slot_active, 4'b1111);
    alien_fire = 1'b1;
    tick();
    alien_fire = 1'b0;
    run_frame();
    chk("full_deny", ag, 0);
    hit = 4'b1000;
    tick();
    hit = '0;
    run_frame();
    chk("no_late_grant", ag, 0);
    chk("late_active", slot_active, 4'b0111);
    chk("slot2_y_pre", sy(2), 24);

    // Hit slot2 in the same cycle MOVE visits it
    frame = 1'b1;
    tick();
    frame = 1'b0;
    repeat (3) tick();
    hit = 4'b0100;
    tick();
    hit = '0;
    tick();
    chk("hit_move_active", slot_active, 4'b0011);
    chk("hit_move_y", sy(2), 24);
    chk("hit_move_y0", sy(0), 48);

    // Frame re-pulsed two cycles after frame
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("overrun", frame_overrun, 1);
    tick();
    chk("overrun_pulse", frame_overrun, 0);
    repeat (2) tick();
    chk("overrun_idle", busy, 0);
    tick();
    chk("no_second_alloc", busy, 0);

    // Reset during MOVE
    frame = 1'b1;
    tick();
    frame = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_active", slot_active, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_xy", slot_x[31:0] | slot_y[31:0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
